// File: rtl/decodificador_eventos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decodificador_eventos                                        |
// | Description : Synchronises five toggle-coded event lines, turns each level |
// |               change into an event code and queues the codes in a small   |
// |               show-ahead FIFO drained over a valid/ready handshake.       |
// | Option      : DECODIF_STAMP_EN adds a 16-bit cycle stamp to each entry.   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module decodificador_eventos #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_W      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              senal_test,
   input  logic              senal_medicina,
   input  logic              senal_energia,
   input  logic              senal_ultrasonido,
   input  logic              senal_fot,
   input  logic              evt_ready,
   input  logic              clr_ovf,
   output logic              evt_valid,
   output logic [2:0]        evt_code,
   output logic [ADDR_W:0]   evt_count,
`ifdef DECODIF_STAMP_EN
   output logic [15:0]       evt_stamp,
`endif
   output logic              overflow
);

   localparam int                NUM_EVT   = 5;
   localparam int                SYNC_W    = SYNC_STAGES * NUM_EVT;
   localparam int                ARM_W     = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0]  ARM_DONE  = ARM_W'(SYNC_STAGES + 1);
   localparam logic [ARM_W-1:0]  ARM_ONE   = ARM_W'(1);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   // Bit 0 is the highest-priority source (test), bit 4 the lowest (fotocelda).
   logic [NUM_EVT-1:0]  w_raw;
   logic [NUM_EVT-1:0]  w_sync_out;
   logic                w_armed;
   logic [NUM_EVT-1:0]  w_event;
   logic                w_pop;
   logic                w_push;
   logic [2:0]          w_sel_idx;
   logic [2:0]          w_push_code;
   logic [NUM_EVT-1:0]  w_clr;
   logic [NUM_EVT-1:0]  w_drop;

   logic [SYNC_W-1:0]   sync_q;
   logic [NUM_EVT-1:0]  prev_q;
   logic [ARM_W-1:0]    arm_q,    arm_d;
   logic [NUM_EVT-1:0]  pend_q,   pend_d;
   logic                ovf_q,    ovf_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q,  count_d;
   logic [2:0]          mem_q [FIFO_DEPTH];

   assign w_raw      = {senal_fot, senal_ultrasonido, senal_energia,
                        senal_medicina, senal_test};
   assign w_sync_out = sync_q[SYNC_W-1 -: NUM_EVT];

   // Synchroniser chain: all five lines shift together, newest sample in the low slice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_W-NUM_EVT-1:0], w_raw};
      end
   end

   // Arming, change detection, fixed-priority selection and pending bookkeeping.
   always_comb begin
      w_armed = (arm_q == ARM_DONE);
      arm_d   = w_armed ? arm_q : (arm_q + ARM_ONE);
      w_event = w_armed ? (w_sync_out ^ prev_q) : '0;
      w_pop   = evt_valid & evt_ready;

      w_sel_idx = '0;
      for (int i = NUM_EVT - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            w_sel_idx = 3'(i);
         end
      end
      w_push      = (|pend_q) && ((count_q < DEPTH_C) || w_pop);
      w_push_code = w_sel_idx + 3'd1;

      w_clr = '0;
      if (w_push) begin
         w_clr[w_sel_idx] = 1'b1;
      end

      // A second toggle while the first is still waiting cannot be represented.
      w_drop = w_event & pend_q & ~w_clr;
      pend_d = (pend_q & ~w_clr) | w_event;
      ovf_d  = (|w_drop) | (ovf_q & ~clr_ovf);
   end

   // FIFO pointer and occupancy update; simultaneous push and pop keeps the count.
   always_comb begin
      wr_ptr_d = w_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = w_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d  = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!w_push && w_pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // Control state registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q   <= '0;
         arm_q    <= '0;
         pend_q   <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         prev_q   <= w_sync_out;
         arm_q    <= arm_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_push_code;
      end
   end

   assign evt_valid = (count_q != '0);
   assign evt_code  = evt_valid ? mem_q[rd_ptr_q] : 3'd0;
   assign evt_count = count_q;
   assign overflow  = ovf_q;

`ifdef DECODIF_STAMP_EN
   logic [15:0] stamp_q;
   logic [15:0] smem_q [FIFO_DEPTH];

   // Free-running cycle counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stamp_q <= '0;
      end else begin
         stamp_q <= stamp_q + 16'd1;
      end
   end

   // Stamp storage written alongside the code on every push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         smem_q[wr_ptr_q] <= stamp_q;
      end
   end

   assign evt_stamp = evt_valid ? smem_q[rd_ptr_q] : 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decodificador_eventos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decodificador_eventos                                     |
// | Description : Self-checking bench with a queue-based reference model,     |
// |               directed scenarios and randomized toggles/handshake.        |
// | Option      : DECODIF_STAMP_EN also checks the head-entry stamp.          |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_decodificador_eventos;

   localparam int SYNC_STAGES = 2;
   localparam int FIFO_DEPTH  = 4;
   localparam int ADDR_W      = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_test = 1'b0, s_med = 1'b0, s_ene = 1'b0, s_ult = 1'b0, s_fot = 1'b0;
   logic              evt_ready = 1'b0;
   logic              clr_ovf = 1'b0;
   logic              evt_valid;
   logic [2:0]        evt_code;
   logic [ADDR_W:0]   evt_count;
   logic              overflow;
`ifdef DECODIF_STAMP_EN
   logic [15:0]       evt_stamp;
`endif

   int unsigned nchecks = 0;
   int unsigned npass   = 0;

   decodificador_eventos #(
      .SYNC_STAGES(SYNC_STAGES),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .senal_test       (s_test),
      .senal_medicina   (s_med),
      .senal_energia    (s_ene),
      .senal_ultrasonido(s_ult),
      .senal_fot        (s_fot),
      .evt_ready        (evt_ready),
      .clr_ovf          (clr_ovf),
      .evt_valid        (evt_valid),
      .evt_code         (evt_code),
      .evt_count        (evt_count),
`ifdef DECODIF_STAMP_EN
      .evt_stamp        (evt_stamp),
`endif
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- reference model ----------------
   // m_samp[k] is the input vector seen at the (k+1)-th edge since reset release.
   logic [4:0]  m_samp[$];
   logic [4:0]  m_pend = '0;
   int          m_q[$];
   int unsigned m_sq[$];
   bit          m_ovf = 1'b0;
   logic [4:0]  m_ev;
   int          m_idx;
   bit          m_pop, m_push, m_drop;
   int          m_n;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_samp.delete();
         m_q.delete();
         m_sq.delete();
         m_pend = '0;
         m_ovf  = 1'b0;
      end else begin
         m_n   = m_samp.size();
         m_pop = (m_q.size() != 0) && evt_ready;
         m_idx = -1;
         for (int i = 0; i < 5; i++) if (m_pend[i] && m_idx < 0) m_idx = i;
         m_push = (m_idx >= 0) && ((m_q.size() < FIFO_DEPTH) || m_pop);
         // A change is visible SYNC_STAGES samples later, once enough history exists.
         m_ev = '0;
         if (m_n >= SYNC_STAGES + 1) m_ev = m_samp[m_n-SYNC_STAGES] ^ m_samp[m_n-SYNC_STAGES-1];
         m_drop = 1'b0;
         for (int i = 0; i < 5; i++)
            if (m_ev[i] && m_pend[i] && !(m_push && m_idx == i)) m_drop = 1'b1;
         if (m_pop) begin
            void'(m_q.pop_front());
            void'(m_sq.pop_front());
         end
         if (m_push) begin
            m_q.push_back(m_idx + 1);
            m_sq.push_back(m_n % 65536);
            m_pend[m_idx] = 1'b0;
         end
         m_pend = m_pend | m_ev;
         m_ovf  = m_drop || (m_ovf && !clr_ovf);
         m_samp.push_back({s_fot, s_ult, s_ene, s_med, s_test});
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("valid", int'(evt_valid), int'(m_q.size() != 0));
      chk("code",  int'(evt_code),  (m_q.size() != 0) ? m_q[0] : 0);
      chk("count", int'(evt_count), m_q.size());
      chk("ovf",   int'(overflow),  int'(m_ovf));
`ifdef DECODIF_STAMP_EN
      chk("stamp", int'(evt_stamp), (m_sq.size() != 0) ? int'(m_sq[0]) : 0);
`endif
   end

   int delivered;
   int maxc;

   initial begin
      #1 reset = 1'b0;
      // 1: stale high level through reset must not produce an event
      s_ene = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      repeat (10) tick();
      chk("t1_valid", int'(evt_valid), 0);
      chk("t1_count", int'(evt_count), 0);

      // 2: single toggle latency SYNC_STAGES+2
      s_med = ~s_med;
      repeat (3) tick();
      chk("t2_early", int'(evt_valid), 0);
      tick();
      chk("t2_valid", int'(evt_valid), 1);
      chk("t2_code",  int'(evt_code), 2);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("t2_pop", int'(evt_valid), 0);

      // 3: five simultaneous toggles serialised by priority
      {s_fot, s_ult, s_ene, s_med, s_test} = ~{s_fot, s_ult, s_ene, s_med, s_test};
      repeat (3) tick();
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t3_count", int'(evt_count), k);
      end
      evt_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         chk("t3_order", int'(evt_code), k);
         tick();
      end
      evt_ready = 1'b0;
      chk("t3_empty", int'(evt_valid), 0);
      chk("t3_ovf",   int'(overflow), 0);

      // 4: second toggle on a still-pending source while full
      {s_fot, s_ult, s_ene, s_med, s_test} = ~{s_fot, s_ult, s_ene, s_med, s_test};
      repeat (7) tick();
      chk("t4_full", int'(evt_count), 4);
      s_fot = ~s_fot;
      repeat (4) tick();
      chk("t4_ovf",   int'(overflow), 1);
      chk("t4_count", int'(evt_count), 4);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("t4_clr", int'(overflow), 0);
      evt_ready = 1'b1;
      repeat (6) tick();
      evt_ready = 1'b0;
      chk("t4_drain", int'(evt_valid), 0);

      // 5: continuous consumption of a periodic toggle stream
      evt_ready = 1'b1;
      delivered = 0;
      maxc = 0;
      for (int t = 0; t < 28; t++) begin
         if (t < 20) s_test = ~s_test;
         repeat (3) begin
            tick();
            if (evt_valid && evt_code == 3'd1) delivered++;
            if (int'(evt_count) > maxc) maxc = int'(evt_count);
         end
      end
      evt_ready = 1'b0;
      chk("t5_delivered", delivered, 20);
      chk("t5_maxcount",  maxc, 1);
      chk("t5_ovf",       int'(overflow), 0);

      // 6: asynchronous reset with entries queued, then re-arm
      s_test = ~s_test;
      s_med  = ~s_med;
      s_ene  = ~s_ene;
      repeat (6) tick();
      chk("t6_queued", int'(evt_count), 3);
      #1 reset = 1'b0;
      #1;
      chk("t6_rst_valid", int'(evt_valid), 0);
      chk("t6_rst_count", int'(evt_count), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (8) tick();
      chk("t6_quiet", int'(evt_count), 0);
      s_med = ~s_med;
      repeat (4) tick();
      chk("t6_valid", int'(evt_valid), 1);
      chk("t6_code",  int'(evt_code), 2);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;

      // Random phase: sparse toggles, throttled consumer, occasional flag clears.
      repeat (500) begin
         if ($urandom_range(0, 7) == 0) s_test = ~s_test;
         if ($urandom_range(0, 7) == 0) s_med  = ~s_med;
         if ($urandom_range(0, 7) == 0) s_ene  = ~s_ene;
         if ($urandom_range(0, 7) == 0) s_ult  = ~s_ult;
         if ($urandom_range(0, 7) == 0) s_fot  = ~s_fot;
         evt_ready = ($urandom_range(0, 2) == 0);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         tick();
      end
      clr_ovf   = 1'b0;
      evt_ready = 1'b1;
      repeat (12) tick();
      chk("final_empty", int'(evt_valid), 0);
      evt_ready = 1'b0;
      tick();

      $display("%0d/%0d checks passed", npass, nchecks);
      $finish;
   end

endmodule
`default_nettype wire
